// File: rtl/rom_reader.sv
// Burst read sequencer for a synchronous-read ROM, exposed as a valid/ready stream.
// Define ROM_READER_CHECKSUM_EN to build the running XOR checksum on chk.
module rom_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] chk
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    OUT,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remain;
  logic              hs;
  logic              last;

  assign hs   = out_valid && out_ready;
  assign last = (remain == {{ADDR_W{1'b0}}, 1'b1});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = FETCH;
      FETCH: state_nx = CAPT;
      CAPT:  state_nx = OUT;
      OUT:   if (hs) state_nx = last ? DONE : FETCH;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rom_en   = (state == FETCH);
    busy     = (state != IDLE);
    done     = (state == DONE);
    rom_addr = addr;
  end

  // len of zero encodes a full 2^ADDR_W word burst
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      remain    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            addr   <= start_addr;
            remain <= (len == '0) ?
                      {1'b1, {ADDR_W{1'b0}}} :
                      {1'b0, len};
          end
        end
        CAPT: begin
          out_data  <= rom_data;
          out_addr  <= addr;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (hs) begin
            out_valid <= 1'b0;
            remain    <= remain - 1'b1;
            if (!last) addr <= addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ROM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      chk_q <= '0;
    else if (state == IDLE && start)
      chk_q <= '0;
    else if (hs)
      chk_q <= chk_q ^ out_data;
  end

  assign chk = chk_q;
`else
  assign chk = '0;
`endif

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader with a behavioural 16x4 registered-read ROM.
// Table of bursts plus hand-written backpressure, busy-start and reset cases.
module tb_rom_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] start_addr;
  logic [3:0] len;
  logic       rom_en;
  logic [3:0] rom_addr;
  logic [3:0] rom_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [3:0] out_addr;
  logic       busy;
  logic       done;
  logic [3:0] chk;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_reader #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .busy       (busy),
    .done       (done),
    .chk        (chk)
  );

  logic [3:0] rom [16] = '{
    4'h2, 4'h2, 4'hE, 4'h2, 4'h6, 4'h3, 4'h8, 4'h6,
    4'h3, 4'h1, 4'hA, 4'h4, 4'hA, 4'hF, 4'h2, 4'h0
  };

  // Data is only meaningful the cycle after en; 5 never appears in the ROM.
  logic       en_q = 1'b0;
  logic [3:0] rom_q = 4'h0;
  always @(posedge clk) begin
    en_q <= rom_en;
    if (rom_en) rom_q <= rom[rom_addr];
  end
  assign rom_data = en_q ? rom_q : 4'h5;

  typedef struct {
    logic [3:0] sa;
    logic [3:0] ln;
    logic [3:0] chk;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ck(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_chk(int v);
`ifdef ROM_READER_CHECKSUM_EN
    return v;
`else
    if (v < 0) return v;
    return 0;
`endif
  endfunction

  task automatic ck_reset_vals(string nm);
    ck({nm, ".rom_en"}, rom_en, 0);
    ck({nm, ".rom_addr"}, rom_addr, 0);
    ck({nm, ".out_valid"}, out_valid, 0);
    ck({nm, ".out_data"}, out_data, 0);
    ck({nm, ".out_addr"}, out_addr, 0);
    ck({nm, ".busy"}, busy, 0);
    ck({nm, ".done"}, done, 0);
    ck({nm, ".chk"}, chk, 0);
  endtask

  // Called in an idle cycle; that cycle is cycle 0 of the burst.
  task automatic run_burst(logic [3:0] sa, logic [3:0] ln, logic [3:0] cv);
    int n;
    logic [3:0] a;
    n = (ln == 0) ? 16 : int'(ln);
    a = sa;
    start = 1'b1;
    start_addr = sa;
    len = ln;
    out_ready = 1'b1;
    for (int w = 0; w < n; w++) begin
      tick();
      start = 1'b0;
      start_addr = ~sa;
      len = 4'h1;
      ck("fetch.rom_en", rom_en, 1);
      ck("fetch.rom_addr", rom_addr, a);
      ck("fetch.out_valid", out_valid, 0);
      ck("fetch.busy", busy, 1);
      tick();
      ck("capt.rom_en", rom_en, 0);
      ck("capt.out_valid", out_valid, 0);
      tick();
      ck("out.valid", out_valid, 1);
      ck("out.data", out_data, rom[a]);
      ck("out.addr", out_addr, a);
      ck("out.rom_en", rom_en, 0);
      ck("out.done", done, 0);
      a = a + 4'd1;
    end
    tick();
    ck("done.pulse", done, 1);
    ck("done.busy", busy, 1);
    ck("done.chk", chk, exp_chk(cv));
    tick();
    ck("idle.done", done, 0);
    ck("idle.busy", busy, 0);
    ck("idle.chk", chk, exp_chk(cv));
  endtask

  initial begin
    vecs[0] = '{sa: 4'd2,  ln: 4'd3, chk: 4'hA};
    vecs[1] = '{sa: 4'd14, ln: 4'd4, chk: 4'h2};
    vecs[2] = '{sa: 4'd0,  ln: 4'd0, chk: 4'hC};
    vecs[3] = '{sa: 4'd15, ln: 4'd1, chk: 4'h0};
    vecs[4] = '{sa: 4'd7,  ln: 4'd2, chk: 4'h5};

    rst_n = 1'b0;
    start = 1'b0;
    start_addr = 4'h0;
    len = 4'h0;
    out_ready = 1'b1;
    tick();
    tick();
    ck_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_burst(vecs[i].sa, vecs[i].ln, vecs[i].chk);

    // backpressure: 5 stalled OUT cycles on word 0 (addr 5, data 3)
    start = 1'b1;
    start_addr = 4'd5;
    len = 4'd2;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      ck("bp.valid", out_valid, 1);
      ck("bp.data", out_data, 4'h3);
      ck("bp.addr", out_addr, 4'd5);
      ck("bp.rom_en", rom_en, 0);
    end
    out_ready = 1'b1;
    tick();
    ck("bp.fetch2.en", rom_en, 1);
    ck("bp.fetch2.addr", rom_addr, 4'd6);
    tick();
    tick();
    ck("bp.w1.data", out_data, 4'h8);
    ck("bp.w1.addr", out_addr, 4'd6);
    tick();
    ck("bp.done", done, 1);
    ck("bp.chk", chk, exp_chk(4'hB));
    tick();

    // start pulsed in FETCH, OUT and DONE must be ignored
    start = 1'b1;
    start_addr = 4'd2;
    len = 4'd3;
    for (int w = 0; w < 3; w++) begin
      tick();
      start = 1'b1;
      start_addr = 4'd9;
      len = 4'd1;
      ck("bs.fetch.addr", rom_addr, 2 + w);
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      ck("bs.out.data", out_data, rom[2 + w]);
      ck("bs.out.addr", out_addr, 2 + w);
    end
    tick();
    ck("bs.done", done, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    ck("bs.after.busy", busy, 0);
    ck("bs.after.done", done, 0);
    tick();

    // reset during OUT of the second word
    start = 1'b1;
    start_addr = 4'd0;
    len = 4'd4;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    ck("rst.pre.valid", out_valid, 1);
    ck("rst.pre.addr", out_addr, 4'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    ck_reset_vals("rst.mid");
    for (int c = 0; c < 4; c++) begin
      tick();
      ck("rst.nodone", done, 0);
      ck("rst.idle", busy, 0);
    end
    run_burst(4'd2, 4'd3, 4'hA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1, "timeout");
  end

endmodule
